rf_access_sequencer: RTL

Port sequencer sitting directly upstream of the 32x32 register file. Arbitrates between operand-fetch requests from the control unit and write-back requests from the ALU/memory stage. Buffers write-backs in a small FIFO and drives the register file's mutually exclusive READ/WRITE controls, so at most one of them is high in any cycle. Captures both read ports into held operand registers with a request/acknowledge handshake.

---
 rtl/rf_access_sequencer.sv | 83 ++++++++
 1 files changed

// File: rtl/rf_access_sequencer.sv
// rf_access_sequencer: write-back FIFO plus read/write port sequencer in front of the 32x32 register file
// Ports: CLK/RST; RD_REQ/RD_ADDR1/RD_ADDR2 -> RD_ACK/OP1/OP2 operand fetch;
// WB_VALID/WB_ADDR/WB_DATA -> WB_READY write-back; BUSY status; RF_* drive the register file.
module rf_access_sequencer #(
  parameter int WB_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RD_REQ,
  input  logic [4:0]  RD_ADDR1,
  input  logic [4:0]  RD_ADDR2,
  output logic        RD_ACK,
  output logic [31:0] OP1,
  output logic [31:0] OP2,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_ADDR,
  input  logic [31:0] WB_DATA,
  output logic        WB_READY,
  output logic        BUSY,
  output logic        RF_READ,
  output logic        RF_WRITE,
  output logic [4:0]  RF_ADDR_R1,
  output logic [4:0]  RF_ADDR_R2,
  output logic [4:0]  RF_ADDR_W,
  output logic [31:0] RF_DATA_W,
  input  logic [31:0] RF_DATA_R1,
  input  logic [31:0] RF_DATA_R2
);
  localparam int AW = $clog2(WB_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;
  state_t state, state_nx;
  logic [4:0] fa [WB_DEPTH];
  logic [31:0] fd [WB_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count, count_nx;
  logic push, pop;
  assign WB_READY = !RST && (count < CW'(WB_DEPTH));
  // writes to R0 complete the handshake but never enter the FIFO
  assign push = WB_VALID && WB_READY && (WB_ADDR != 5'd0);
  assign pop = state == WR;
  assign count_nx = count + CW'(push) - CW'(pop);
  assign RF_WRITE = state == WR;
  assign RF_READ = state == RD;
  assign RD_ACK = state == ACK;
  assign BUSY = (state != IDLE) || (count != '0);
  assign RF_ADDR_W = RF_WRITE ? fa[rp] : 5'd0;
  assign RF_DATA_W = RF_WRITE ? fd[rp] : 32'd0;
  assign RF_ADDR_R1 = RF_READ ? RD_ADDR1 : 5'd0;
  assign RF_ADDR_R2 = RF_READ ? RD_ADDR2 : 5'd0;
  // the post-push count gates reads, so a write accepted on the same edge as a request still lands first
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == RD) ? ACK :
               (count_nx != '0) ? WR :
               (state != ACK && RD_REQ) ? RD : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      OP1 <= '0;
      OP2 <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (state == RD) begin
        OP1 <= RF_DATA_R1;
        OP2 <= RF_DATA_R2;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      fa[wp] <= WB_ADDR;
      fd[wp] <= WB_DATA;
    end
  end
endmodule
